// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT sequencer and datapath.
//   N, LOG2N : transform size and address width
//   state_t  : sequencer FSM states
//   bitrev3  : 3-bit bit reversal used for the input load order
package fft8_pkg;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, DONE} state_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction
endpackage

// File: rtl/fft8_delay_line.sv
// Fixed-depth shift register carrying {valid, payload} from butterfly issue to
// result write-back. The MSB of each word is the valid bit.
//   i_clk, i_rst : clock, synchronous active-high reset (flushes the pipe)
//   i_data       : word entering the pipe this cycle
//   o_data       : word leaving the pipe (DEPTH cycles after entry)
//   o_pend       : a valid word is still in flight behind the output stage
module fft8_delay_line #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_pend
);
  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_data = r_pipe[DEPTH-1];

  // Only stages behind the output count: once the last write is on o_data the
  // memory is updated at the coming edge, so the next stage may start reading.
  always_comb begin
    o_pend = 1'b0;
    for (int i = 0; i < DEPTH-1; i++) o_pend = o_pend | r_pipe[i][WIDTH-1];
  end
endmodule

// File: rtl/fft8_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT 8-point FFT: loads 8 samples in
// (optionally) bit-reversed order, then issues 3 stages x 4 butterflies,
// draining the butterfly pipe between stages.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start a transform (IDLE only)
//   i_in_valid          : input sample present
//   o_in_ready/o_load_we/o_load_addr : sample load handshake and address
//   o_rom_en/o_rom_index: twiddle ROM request on issue cycles
//   o_rd_addr_a/b       : butterfly operand read addresses
//   o_bf_valid          : ROM/memory data valid (issue + 1)
//   o_wr_en/o_wr_addr_a/b : result write-back (issue + 1 + BF_LAT)
//   o_stage, o_busy, o_done : status
module fft8_seq_ctrl
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2,
  parameter bit BITREV = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_load_we,
  output logic [LOG2N-1:0] o_load_addr,
  output logic             o_rom_en,
  output logic [LOG2N-1:0] o_rom_index,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic             o_bf_valid,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b,
  output logic [1:0]       o_stage,
  output logic             o_busy,
  output logic             o_done
);
  localparam int DLW = 1 + 2*LOG2N;

  state_t           r_state, w_next;
  logic [LOG2N-1:0] r_cnt;      // sample count in LOAD, butterfly index in CALC
  logic [1:0]       r_stage;
  logic             r_bf_valid;
  logic             w_accept, w_issue, w_pend;
  logic [LOG2N-1:0] w_rd_a, w_rd_b, w_idx;
  logic [DLW-1:0]   w_dl_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_in_ready  = 1'b0;
    w_accept    = 1'b0;
    o_load_addr = '0;
    w_issue     = 1'b0;
    w_rd_a      = '0;
    w_rd_b      = '0;
    w_idx       = '0;
    o_stage     = '0;
    o_done      = 1'b0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE: if (i_start) w_next = LOAD;
      LOAD: begin
        o_in_ready  = 1'b1;
        w_accept    = i_in_valid;
        o_load_addr = BITREV ? bitrev3(r_cnt) : r_cnt;
        if (w_accept && r_cnt == LOG2N'(N-1)) w_next = CALC;
      end
      CALC: begin
        w_issue = 1'b1;
        o_stage = r_stage;
        // a = grp*2*span + pos, b = a + span, k = pos << (2-s)
        case (r_stage)
          2'd0: begin
            w_rd_a = {r_cnt[1:0], 1'b0};
            w_rd_b = {r_cnt[1:0], 1'b1};
          end
          2'd1: begin
            w_rd_a = {r_cnt[1], 1'b0, r_cnt[0]};
            w_rd_b = {r_cnt[1], 1'b1, r_cnt[0]};
            w_idx  = {1'b0, r_cnt[0], 1'b0};
          end
          2'd2: begin
            w_rd_a = {1'b0, r_cnt[1:0]};
            w_rd_b = {1'b1, r_cnt[1:0]};
            w_idx  = {1'b0, r_cnt[1:0]};
          end
          default: ;
        endcase
        if (r_cnt[1:0] == 2'd3) w_next = DRAIN;
      end
      DRAIN: begin
        o_stage = r_stage;
        if (!w_pend) w_next = (r_stage == 2'd2) ? DONE : CALC;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_stage    <= '0;
      r_bf_valid <= 1'b0;
    end else begin
      r_bf_valid <= w_issue;
      case (r_state)
        LOAD:  if (w_accept) r_cnt <= r_cnt + 1'b1;  // wraps to 0 for CALC
        CALC:  r_cnt <= (r_cnt[1:0] == 2'd3) ? '0 : r_cnt + 1'b1;
        DRAIN: if (!w_pend && r_stage != 2'd2) r_stage <= r_stage + 1'b1;
        default: begin
          r_cnt   <= '0;
          r_stage <= '0;
        end
      endcase
    end
  end

  fft8_delay_line #(.WIDTH(DLW), .DEPTH(1 + BF_LAT)) u_wr_dly (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_data ({w_issue, w_rd_a, w_rd_b}),
    .o_data (w_dl_out),
    .o_pend (w_pend)
  );

  assign o_load_we   = w_accept;
  assign o_rom_en    = w_issue;
  assign o_rom_index = w_idx;
  assign o_rd_addr_a = w_rd_a;
  assign o_rd_addr_b = w_rd_b;
  assign o_bf_valid  = r_bf_valid;
  assign {o_wr_en, o_wr_addr_a, o_wr_addr_b} = w_dl_out;
endmodule

// File: tb/tb_fft8_seq_ctrl.sv
// Directed bench for fft8_seq_ctrl (BF_LAT=2, BITREV=1): reset, loads with and
// without gaps, a cycle-by-cycle table of the full CALC/DRAIN/DONE sequence,
// done latency, and reset in the middle of stage 1.
module tb_fft8_seq_ctrl;
  logic       clk, rst, start, in_valid;
  logic       in_ready, load_we, rom_en, bf_valid, wr_en, busy, done;
  logic [2:0] load_addr, rom_index, rd_a, rd_b, wr_a, wr_b;
  logic [1:0] stage;

  int n_cmp = 0;
  int n_bad = 0;

  fft8_seq_ctrl #(.BF_LAT(2), .BITREV(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .o_load_we(load_we), .o_load_addr(load_addr),
    .o_rom_en(rom_en), .o_rom_index(rom_index),
    .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_bf_valid(bf_valid),
    .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b),
    .o_stage(stage), .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [21:0] exp;
  } vec_t;

  vec_t       tbl[23];
  logic [2:0] exp_la[8];

  function automatic vec_t mk(input logic s, iv, re, input logic [2:0] ra, rb, ix,
                              input logic bv, we, input logic [2:0] wa, wb,
                              input logic [1:0] st, input logic dn, bz);
    vec_t v;
    v.start = s; v.in_valid = iv;
    v.exp = {re, ra, rb, ix, bv, we, wa, wb, st, dn, bz};
    return v;
  endfunction

  // Addresses only matter while their strobe is high.
  function automatic logic [21:0] act_vec();
    return {rom_en, rom_en ? rd_a : 3'd0, rom_en ? rd_b : 3'd0, rom_en ? rom_index : 3'd0,
            bf_valid, wr_en, wr_en ? wr_a : 3'd0, wr_en ? wr_b : 3'd0, stage, done, busy};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
  endtask

  // Feeds samples until 8 accepts; gaps=1 uses the 1,0,0,1,... pattern and
  // holds start high to show it is ignored in LOAD.
  task automatic run_load(input bit gaps);
    int acc = 0;
    int cyc = 0;
    while (acc < 8 && cyc < 64) begin
      @(negedge clk);
      start    = gaps;
      in_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      #1;
      chk("load_ready", {31'd0, in_ready}, 32'd1);
      chk("load_we", {31'd0, load_we}, {31'd0, in_valid});
      if (in_valid) begin
        chk($sformatf("load_addr%0d", acc), {29'd0, load_addr}, {29'd0, exp_la[acc]});
        acc++;
      end
      cyc++;
    end
    if (acc < 8) chk("load_timeout", acc, 8);
    if (gaps) chk("load_gap_cycles", cyc, 22);
  endtask

  initial begin
    exp_la = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    //            st iv  re ra rb ix bv we wa wb st dn bz
    tbl[0]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 1, 4, 5, 0, 1, 0, 0, 0, 0, 0, 1);
    tbl[3]  = mk(0, 0, 1, 6, 7, 0, 1, 1, 0, 1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 0, 0, 1);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 5, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 7, 0, 0, 1);
    tbl[7]  = mk(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 1);
    tbl[8]  = mk(0, 0, 1, 1, 3, 2, 1, 0, 0, 0, 1, 0, 1);
    tbl[9]  = mk(1, 0, 1, 4, 6, 0, 1, 0, 0, 0, 1, 0, 1);
    tbl[10] = mk(0, 0, 1, 5, 7, 2, 1, 1, 0, 2, 1, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 1, 0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 6, 1, 0, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 7, 1, 0, 1);
    tbl[14] = mk(0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 2, 0, 1);
    tbl[15] = mk(0, 0, 1, 1, 5, 1, 1, 0, 0, 0, 2, 0, 1);
    tbl[16] = mk(0, 0, 1, 2, 6, 2, 1, 0, 0, 0, 2, 0, 1);
    tbl[17] = mk(0, 0, 1, 3, 7, 3, 1, 1, 0, 4, 2, 0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 2, 0, 1);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 6, 2, 0, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 7, 2, 0, 1);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outs", {27'd0, busy, rom_en, wr_en, done, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back load, then the full sequence cycle by cycle.
    kick();
    run_load(1'b0);
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      start = tbl[c].start; in_valid = tbl[c].in_valid;
      #1;
      chk($sformatf("seq_c%0d", c), {10'd0, act_vec()}, {10'd0, tbl[c].exp});
      if (tbl[c].in_valid) chk($sformatf("no_load_c%0d", c), {31'd0, load_we}, 32'd0);
    end

    // Load with gaps, then measure LOAD exit to done.
    kick();
    run_load(1'b1);
    begin
      int n = 0;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
      #1;
      chk("gap_calc_entry", {10'd0, act_vec()}, {10'd0, tbl[0].exp});
      while (!done && n < 60) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("done_latency", n, 21);
      @(negedge clk);
      #1;
      chk("done_one_pulse", {30'd0, done, busy}, 32'd0);
    end

    // Reset during stage-1 CALC drops pending writes.
    kick();
    run_load(1'b0);
    repeat (9) @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    #1;
    chk("pre_rst_stage1", {30'd0, stage}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_idle", {27'd0, busy, rom_en, wr_en, bf_valid, |stage}, 32'd0);
    rst = 1'b0;
    begin
      int wr_seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        #1;
        if (wr_en || busy) wr_seen++;
      end
      chk("rst_no_wr", wr_seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
